// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the load/store unit
package riscv_pkg;

  typedef enum logic {
    LSU_BYTE = 1'b0,
    LSU_HALF = 1'b1
  } lsu_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  localparam logic [1:0] LSU_BE_HALF = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and lane select/extension for loads
module lsu_align
  import riscv_pkg::*;
(
  input  lsu_size_t   size,
  input  logic        addr_lsb,
  input  logic        is_unsigned,
  input  logic [15:0] st_data,
  input  logic [15:0] ld_data,
  output logic [1:0]  be,
  output logic [15:0] st_lanes,
  output logic [15:0] ld_result
);

  logic [7:0] ld_byte;

  always_comb begin
    be        = LSU_BE_HALF;
    st_lanes  = st_data;
    ld_result = ld_data;
    ld_byte   = addr_lsb ? ld_data[15:8] : ld_data[7:0];
    if (size == LSU_BYTE) begin
      be        = addr_lsb ? 2'b10 : 2'b01;
      // Replicating the byte lets memory pick whichever lane be selects.
      st_lanes  = {st_data[7:0], st_data[7:0]};
      ld_result = is_unsigned ? {8'h00, ld_byte} : {{8{ld_byte[7]}}, ld_byte};
    end
  end

endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - memory-stage load/store unit with req/gnt/rvalid bus handshake; optional LSU_BUS_TIMEOUT_EN bus wait limit
module lsu_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic        op_load_i,
  input  logic        op_size_i,
  input  logic        op_unsigned_i,
  input  logic [15:0] op_addr_i,
  input  logic [15:0] op_wdata_i,
  input  logic [2:0]  op_rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [14:0] dmem_addr_o,
  output logic [1:0]  dmem_be_o,
  output logic [15:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [15:0] dmem_rdata_i,
  output logic        done_o,
  output logic [15:0] read_data_o,
  output logic [2:0]  rd_addr_o,
  output logic        write_en_o,
  output logic        err_o,
  output logic        err_timeout_o
);

  lsu_state_t  state, next;
  logic        accept, misaligned, capture, to_err, timeout, in_req;
  logic        load_q, unsigned_q, err_q, err_to_q;
  lsu_size_t   size_q;
  logic [15:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  rd_q;
  logic [1:0]  be_w;
  logic [15:0] st_lanes_w, ld_result_w;

  assign misaligned = op_size_i & op_addr_i[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= LSU_IDLE;
    else       state <= next;
  end

  always_comb begin
    next    = state;
    accept  = 1'b0;
    capture = 1'b0;
    to_err  = 1'b0;
    case (state)
      LSU_IDLE: if (op_valid_i) begin
        accept = 1'b1;
        next   = misaligned ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: if (dmem_gnt_i) begin
        next = load_q ? LSU_RESP : LSU_DONE;
      end else if (timeout) begin
        next   = LSU_DONE;
        to_err = 1'b1;
      end
      LSU_RESP: if (dmem_rvalid_i) begin
        next    = LSU_DONE;
        capture = 1'b1;
      end else if (timeout) begin
        next   = LSU_DONE;
        to_err = 1'b1;
      end
      default: next = LSU_IDLE;
    endcase
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // wait_cnt holds the number of earlier absent cycles, so wait cycle N sees N-1.
  assign timeout = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                        wait_cnt <= '0;
    else if (state != next)                           wait_cnt <= '0;
    else if (state == LSU_REQ || state == LSU_RESP)   wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_q     <= 1'b0;
      size_q     <= LSU_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_to_q   <= 1'b0;
    end else if (accept) begin
      load_q     <= op_load_i;
      size_q     <= lsu_size_t'(op_size_i);
      unsigned_q <= op_unsigned_i;
      addr_q     <= op_addr_i;
      wdata_q    <= op_wdata_i;
      rd_q       <= op_rd_i;
      rdata_q    <= '0;
      err_q      <= misaligned;
      err_to_q   <= 1'b0;
    end else if (capture) begin
      rdata_q <= ld_result_w;
    end else if (to_err) begin
      err_q    <= 1'b1;
      err_to_q <= 1'b1;
    end
  end

  lsu_align u_align (
    .size        (size_q),
    .addr_lsb    (addr_q[0]),
    .is_unsigned (unsigned_q),
    .st_data     (wdata_q),
    .ld_data     (dmem_rdata_i),
    .be          (be_w),
    .st_lanes    (st_lanes_w),
    .ld_result   (ld_result_w)
  );

  // Bus outputs are gated by state so nothing toggles on the bus outside REQ.
  assign in_req       = (state == LSU_REQ);
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req & ~load_q;
  assign dmem_addr_o  = in_req ? addr_q[15:1] : '0;
  assign dmem_be_o    = in_req ? be_w : '0;
  assign dmem_wdata_o = in_req ? st_lanes_w : '0;

  assign op_ready_o    = (state == LSU_IDLE);
  assign done_o        = (state == LSU_DONE);
  assign read_data_o   = rdata_q;
  assign rd_addr_o     = rd_q;
  assign err_o         = err_q;
  assign err_timeout_o = err_to_q;
  assign write_en_o    = done_o & load_q & ~err_q;

endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - directed self-checking bench for lsu_unit
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready, op_load, op_size, op_unsigned;
  logic [15:0] op_addr, op_wdata;
  logic [2:0]  op_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [14:0] dmem_addr;
  logic [1:0]  dmem_be;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic        done, write_en, err, err_timeout;
  logic [15:0] read_data;
  logic [2:0]  rd_addr;

  int errors = 0;
  int checks = 0;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 5;
`endif

  always #5 clk = ~clk;

  lsu_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .op_valid_i    (op_valid),
    .op_ready_o    (op_ready),
    .op_load_i     (op_load),
    .op_size_i     (op_size),
    .op_unsigned_i (op_unsigned),
    .op_addr_i     (op_addr),
    .op_wdata_i    (op_wdata),
    .op_rd_i       (op_rd),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_addr_o   (dmem_addr),
    .dmem_be_o     (dmem_be),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_gnt_i    (dmem_gnt),
    .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i  (dmem_rdata),
    .done_o        (done),
    .read_data_o   (read_data),
    .rd_addr_o     (rd_addr),
    .write_en_o    (write_en),
    .err_o         (err),
    .err_timeout_o (err_timeout)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle; afterwards the unit is in REQ (or DONE if misaligned).
  task automatic issue(input logic ld, input logic sz, input logic uns,
                       input logic [15:0] addr, input logic [15:0] wd, input logic [2:0] rd);
    op_valid = 1'b1; op_load = ld; op_size = sz; op_unsigned = uns;
    op_addr = addr; op_wdata = wd; op_rd = rd;
    tick();
    op_valid = 1'b0; op_load = 1'b0; op_size = 1'b0; op_unsigned = 1'b0;
    op_addr = '0; op_wdata = '0; op_rd = '0;
  endtask

  // From REQ: gnt immediately, rvalid next cycle; returns in DONE.
  task automatic load_fast(input logic [15:0] rdata);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    op_valid = 1'b0; op_load = 1'b0; op_size = 1'b0; op_unsigned = 1'b0;
    op_addr = '0; op_wdata = '0; op_rd = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick(); tick();

    check("rst_ready", 16'(op_ready), 16'd1);
    check("rst_done", 16'(done), 16'd0);
    check("rst_req", 16'(dmem_req), 16'd0);
    check("rst_be", 16'(dmem_be), 16'd0);
    check("rst_rdata", read_data, 16'h0000);
    check("rst_err", 16'({err, err_timeout, write_en}), 16'd0);
    rst = 1'b0;
    tick();

    // Halfword load 0x0010 -> 0xBEEF, rd=5
    issue(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 3'd5);
    check("hl_req", 16'(dmem_req), 16'd1);
    check("hl_addr", 16'(dmem_addr), 16'h0008);
    check("hl_be", 16'(dmem_be), 16'h0003);
    check("hl_we", 16'(dmem_we), 16'd0);
    check("hl_ready", 16'(op_ready), 16'd0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("hl_resp_req", 16'(dmem_req), 16'd0);
    check("hl_resp_done", 16'(done), 16'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 16'hBEEF;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    check("hl_done", 16'(done), 16'd1);
    check("hl_data", read_data, 16'hBEEF);
    check("hl_rd", 16'(rd_addr), 16'd5);
    check("hl_we_out", 16'(write_en), 16'd1);
    check("hl_err", 16'(err), 16'd0);
    tick();
    check("hl_done_pulse", 16'(done), 16'd0);
    check("hl_hold", read_data, 16'hBEEF);
    check("hl_ready_again", 16'(op_ready), 16'd1);

    // Signed byte load, high lane
    issue(1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000, 3'd2);
    check("sb_be", 16'(dmem_be), 16'h0002);
    load_fast(16'h80FF);
    check("sb_done", 16'(done), 16'd1);
    check("sb_data", read_data, 16'hFF80);
    check("sb_rd", 16'(rd_addr), 16'd2);
    tick();

    // Unsigned byte load, high lane
    issue(1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, 3'd3);
    load_fast(16'h80FF);
    check("ub_data", read_data, 16'h0080);
    tick();

    // Signed byte load, low lane
    issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 3'd4);
    check("sb0_be", 16'(dmem_be), 16'h0001);
    load_fast(16'h80FF);
    check("sb0_data", read_data, 16'hFFFF);
    tick();

    // Byte store 0x12A5 to 0x0021
    issue(1'b0, 1'b0, 1'b0, 16'h0021, 16'h12A5, 3'd0);
    check("bs_addr", 16'(dmem_addr), 16'h0010);
    check("bs_be", 16'(dmem_be), 16'h0002);
    check("bs_wdata", dmem_wdata, 16'hA5A5);
    check("bs_we", 16'(dmem_we), 16'd1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("bs_done", 16'(done), 16'd1);
    check("bs_wen", 16'(write_en), 16'd0);
    check("bs_rdata", read_data, 16'h0000);
    check("bs_err", 16'(err), 16'd0);
    tick();

    // Misaligned halfword load
    issue(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 3'd6);
    check("mis_done", 16'(done), 16'd1);
    check("mis_req", 16'(dmem_req), 16'd0);
    check("mis_err", 16'(err), 16'd1);
    check("mis_to", 16'(err_timeout), 16'd0);
    check("mis_wen", 16'(write_en), 16'd0);
    tick();
    check("mis_idle", 16'(op_ready), 16'd1);

    // Halfword store with gnt withheld
    issue(1'b0, 1'b1, 1'b0, 16'h0040, 16'h1234, 3'd0);
    for (int i = 0; i < HOLD; i++) begin
      check("hold_req", 16'(dmem_req), 16'd1);
      check("hold_addr", 16'(dmem_addr), 16'h0020);
      check("hold_be", 16'(dmem_be), 16'h0003);
      check("hold_wdata", dmem_wdata, 16'h1234);
      check("hold_ready", 16'(op_ready), 16'd0);
      tick();
    end
    check("hold_still_req", 16'(dmem_req), 16'd1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("hold_done", 16'(done), 16'd1);
    check("hold_err", 16'(err), 16'd0);
    tick();

`ifdef LSU_BUS_TIMEOUT_EN
    // gnt never comes: four wait cycles, then error completion
    issue(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0000, 3'd1);
    for (int i = 0; i < 4; i++) begin
      check("to_wait_req", 16'(dmem_req), 16'd1);
      tick();
    end
    check("to_done", 16'(done), 16'd1);
    check("to_err", 16'(err), 16'd1);
    check("to_cause", 16'(err_timeout), 16'd1);
    check("to_req", 16'(dmem_req), 16'd0);
    check("to_wen", 16'(write_en), 16'd0);
    tick();

    // gnt in the final wait cycle wins
    issue(1'b0, 1'b1, 1'b0, 16'h0050, 16'h5555, 3'd0);
    tick(); tick(); tick();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("to_late_done", 16'(done), 16'd1);
    check("to_late_err", 16'(err), 16'd0);
    tick();
`endif

    // Reset while in RESP; a late rvalid must be dropped
    issue(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0000, 3'd7);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("rr_req", 16'(dmem_req), 16'd0);
    check("rr_done", 16'(done), 16'd0);
    check("rr_ready", 16'(op_ready), 16'd1);
    check("rr_rd", 16'(rd_addr), 16'd0);
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 16'hFFFF;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    check("rr_late_done", 16'(done), 16'd0);
    check("rr_late_data", read_data, 16'h0000);
    check("rr_late_ready", 16'(op_ready), 16'd1);
    tick();
    check("rr_after_done", 16'(done), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
